// File: rtl/sdram_arbit_if.sv
// Sequencer-side and pin-side signals of the SDRAM command-bus arbiter.
// Handshake: a sequencer holds *_req until it sees its *_en grant, drives its
// cmd/bank/addr for as long as *_en is high, and releases the bus with a
// one-cycle *_end pulse; the grant drops on the edge that samples that pulse.
interface sdram_arbit_if #(
  parameter int ADDR_W = 13,
  parameter int DQ_W   = 16
);
  logic              init_end;
  logic [3:0]        init_cmd;
  logic [1:0]        init_bank;
  logic [ADDR_W-1:0] init_addr;

  logic              ar_req,  wr_req,  rd_req;
  logic              ar_end,  wr_end,  rd_end;
  logic [3:0]        ar_cmd,  wr_cmd,  rd_cmd;
  logic [1:0]        ar_bank, wr_bank, rd_bank;
  logic [ADDR_W-1:0] ar_addr, wr_addr, rd_addr;
  logic              wr_dq_en;
  logic [DQ_W-1:0]   wr_dq_data;

  logic              ar_en, wr_en, rd_en;
  logic              sdram_cke;
  logic [3:0]        sdram_cmd;
  logic [1:0]        sdram_bank;
  logic [ADDR_W-1:0] sdram_addr;
  logic              sdram_dq_oe;
  logic [DQ_W-1:0]   sdram_dq_out;

  modport slave (
    input  init_end, init_cmd, init_bank, init_addr,
    input  ar_req, wr_req, rd_req, ar_end, wr_end, rd_end,
    input  ar_cmd, wr_cmd, rd_cmd, ar_bank, wr_bank, rd_bank,
    input  ar_addr, wr_addr, rd_addr, wr_dq_en, wr_dq_data,
    output ar_en, wr_en, rd_en, sdram_cke, sdram_cmd, sdram_bank,
    output sdram_addr, sdram_dq_oe, sdram_dq_out
  );

  modport master (
    output init_end, init_cmd, init_bank, init_addr,
    output ar_req, wr_req, rd_req, ar_end, wr_end, rd_end,
    output ar_cmd, wr_cmd, rd_cmd, ar_bank, wr_bank, rd_bank,
    output ar_addr, wr_addr, rd_addr, wr_dq_en, wr_dq_data,
    input  ar_en, wr_en, rd_en, sdram_cke, sdram_cmd, sdram_bank,
    input  sdram_addr, sdram_dq_oe, sdram_dq_out
  );
endinterface

// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: init pass-through until init_end, then fixed
// priority auto-refresh > write > read, NOP whenever nobody owns the bus.
module sdram_arbit #(
  parameter int ADDR_W = 13,
  parameter int DQ_W   = 16
) (
  input  logic         arbit_clk,
  input  logic         arbit_rst_n,
  sdram_arbit_if.slave bus,
  output logic [2:0]   o_dbg_state
);
  localparam logic [3:0] NOP = 4'b0111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARBIT = 3'd1,
    AREF  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        w_cmd;
  logic [1:0]        w_bank;
  logic [ADDR_W-1:0] w_addr;
  logic              w_dq_oe;

  always_ff @(posedge arbit_clk or negedge arbit_rst_n) begin
    if (!arbit_rst_n) r_state <= IDLE;
    else              r_state <= w_next;
  end

  // Owners only leave on their own end pulse, so every hand-over passes ARBIT.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (bus.init_end) w_next = ARBIT;
      ARBIT: begin
        if      (bus.ar_req) w_next = AREF;
        else if (bus.wr_req) w_next = WRITE;
        else if (bus.rd_req) w_next = READ;
      end
      AREF:  if (bus.ar_end) w_next = ARBIT;
      WRITE: if (bus.wr_end) w_next = ARBIT;
      READ:  if (bus.rd_end) w_next = ARBIT;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_cmd  = NOP;
    w_bank = '0;
    w_addr = '0;
    case (r_state)
      IDLE: begin
        w_cmd  = bus.init_cmd;
        w_bank = bus.init_bank;
        w_addr = bus.init_addr;
      end
      AREF: begin
        w_cmd  = bus.ar_cmd;
        w_bank = bus.ar_bank;
        w_addr = bus.ar_addr;
      end
      WRITE: begin
        w_cmd  = bus.wr_cmd;
        w_bank = bus.wr_bank;
        w_addr = bus.wr_addr;
      end
      READ: begin
        w_cmd  = bus.rd_cmd;
        w_bank = bus.rd_bank;
        w_addr = bus.rd_addr;
      end
      default: ;
    endcase
  end

  assign w_dq_oe = (r_state == WRITE) & bus.wr_dq_en;

  assign bus.ar_en        = (r_state == AREF);
  assign bus.wr_en        = (r_state == WRITE);
  assign bus.rd_en        = (r_state == READ);
  assign bus.sdram_cke    = 1'b1;
  assign bus.sdram_cmd    = w_cmd;
  assign bus.sdram_bank   = w_bank;
  assign bus.sdram_addr   = w_addr;
  assign bus.sdram_dq_oe  = w_dq_oe;
  assign bus.sdram_dq_out = w_dq_oe ? bus.wr_dq_data : '0;
  assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: directed scenarios plus a randomized run against an
// owner-based reference model.
module tb_sdram_arbit;
  localparam int ADDR_W = 13;
  localparam int DQ_W   = 16;
  localparam logic [3:0] NOP = 4'b0111;

  logic       arbit_clk;
  logic       arbit_rst_n;
  logic [2:0] dbg_state;
  int         errors = 0;
  int         checks = 0;

  sdram_arbit_if #(.ADDR_W(ADDR_W), .DQ_W(DQ_W)) bus ();

  sdram_arbit #(.ADDR_W(ADDR_W), .DQ_W(DQ_W)) dut (
    .arbit_clk   (arbit_clk),
    .arbit_rst_n (arbit_rst_n),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial arbit_clk = 1'b0;
  always #5 arbit_clk = ~arbit_clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // reference model: who owns the bus, and has init completed
  bit m_init;
  int m_owner;

  task automatic model_reset();
    m_init  = 1'b0;
    m_owner = -1;
  endtask

  task automatic model_edge();
    bit req[3];
    bit fin[3];
    req = '{bus.ar_req, bus.wr_req, bus.rd_req};
    fin = '{bus.ar_end, bus.wr_end, bus.rd_end};
    if (!m_init) begin
      if (bus.init_end) m_init = 1'b1;
    end else if (m_owner < 0) begin
      for (int k = 2; k >= 0; k--) if (req[k]) m_owner = k;
    end else if (fin[m_owner]) begin
      m_owner = -1;
    end
  endtask

  // driver tasks
  task automatic clear_inputs();
    bus.init_end = 0; bus.init_cmd = 4'b0010; bus.init_bank = 2'd2;
    bus.init_addr = 13'h0123;
    bus.ar_req = 0; bus.wr_req = 0; bus.rd_req = 0;
    bus.ar_end = 0; bus.wr_end = 0; bus.rd_end = 0;
    bus.ar_cmd = 4'b0001; bus.ar_bank = 2'd1; bus.ar_addr = 13'h0400;
    bus.wr_cmd = 4'b0100; bus.wr_bank = 2'd2; bus.wr_addr = 13'h0ABC;
    bus.rd_cmd = 4'b0101; bus.rd_bank = 2'd3; bus.rd_addr = 13'h1F0F;
    bus.wr_dq_en = 0; bus.wr_dq_data = '0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge arbit_clk);
    #1;
  endtask

  task automatic apply_reset();
    arbit_rst_n = 1'b0;
    repeat (2) @(posedge arbit_clk);
    @(negedge arbit_clk);
    arbit_rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.wr_dq_en = 1; bus.wr_dq_data = 16'hFFFF;
    apply_reset();
    checks++;
    if ({bus.sdram_cmd, bus.sdram_bank, bus.sdram_addr} !== {4'b0010, 2'd2, 13'h0123}) begin
      errors++;
      $display("FAIL reset_bus got=%h exp=%h", {bus.sdram_cmd, bus.sdram_bank, bus.sdram_addr},
               {4'b0010, 2'd2, 13'h0123});
    end
    checks++;
    if ({bus.ar_en, bus.wr_en, bus.rd_en, bus.sdram_cke} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_grants_cke got=%b exp=0001", {bus.ar_en, bus.wr_en, bus.rd_en, bus.sdram_cke});
    end
    checks++;
    if ({bus.sdram_dq_oe, bus.sdram_dq_out} !== 17'h0) begin
      errors++;
      $display("FAIL reset_dq got=%h exp=0", {bus.sdram_dq_oe, bus.sdram_dq_out});
    end
    bus.wr_dq_en = 0;
    bus.ar_req = 1;
    step(3);
    checks++;
    if ({bus.ar_en, bus.sdram_cmd} !== {1'b0, 4'b0010}) begin
      errors++;
      $display("FAIL idle_ignores_req got=%b exp=00010", {bus.ar_en, bus.sdram_cmd});
    end
    bus.ar_req = 0;
  endtask

  task automatic test_init_end();
    bus.init_end = 1;
    step(1);
    checks++;
    if ({bus.sdram_cmd, bus.sdram_bank, bus.sdram_addr} !== {NOP, 2'd0, 13'h0}) begin
      errors++;
      $display("FAIL init_end_nop got=%h exp=%h", {bus.sdram_cmd, bus.sdram_bank, bus.sdram_addr},
               {NOP, 2'd0, 13'h0});
    end
    bus.init_end = 0;
    step(3);
    checks++;
    if ({bus.ar_en, bus.wr_en, bus.rd_en, bus.sdram_cmd} !== {3'b000, NOP}) begin
      errors++;
      $display("FAIL init_sticky got=%b exp=0000111", {bus.ar_en, bus.wr_en, bus.rd_en, bus.sdram_cmd});
    end
  endtask

  task automatic test_priority();
    bus.ar_req = 1; bus.wr_req = 1; bus.rd_req = 1;
    step(1);
    checks++;
    if ({bus.ar_en, bus.wr_en, bus.rd_en} !== 3'b100) begin
      errors++;
      $display("FAIL prio_ar_wins got=%b exp=100", {bus.ar_en, bus.wr_en, bus.rd_en});
    end
    checks++;
    if ({bus.sdram_cmd, bus.sdram_bank, bus.sdram_addr} !== {4'b0001, 2'd1, 13'h0400}) begin
      errors++;
      $display("FAIL prio_ar_bus got=%h exp=%h", {bus.sdram_cmd, bus.sdram_bank, bus.sdram_addr},
               {4'b0001, 2'd1, 13'h0400});
    end
    bus.ar_req = 0;
    step(2);
    bus.ar_end = 1;
    step(1);
    bus.ar_end = 0;
    checks++;
    if ({bus.ar_en, bus.wr_en, bus.rd_en, bus.sdram_cmd} !== {3'b000, NOP}) begin
      errors++;
      $display("FAIL prio_gap_after_ar got=%b exp=0000111", {bus.ar_en, bus.wr_en, bus.rd_en, bus.sdram_cmd});
    end
    step(1);
    checks++;
    if ({bus.ar_en, bus.wr_en, bus.rd_en, bus.sdram_cmd} !== {3'b010, 4'b0100}) begin
      errors++;
      $display("FAIL prio_wr_next got=%b exp=0100100", {bus.ar_en, bus.wr_en, bus.rd_en, bus.sdram_cmd});
    end
    bus.wr_req = 0;
    step(1);
    bus.wr_end = 1;
    step(1);
    bus.wr_end = 0;
    step(1);
    checks++;
    if ({bus.ar_en, bus.wr_en, bus.rd_en, bus.sdram_cmd, bus.sdram_addr} !== {3'b001, 4'b0101, 13'h1F0F}) begin
      errors++;
      $display("FAIL prio_rd_last got=%h exp=%h", {bus.ar_en, bus.wr_en, bus.rd_en, bus.sdram_cmd, bus.sdram_addr},
               {3'b001, 4'b0101, 13'h1F0F});
    end
    bus.rd_req = 0;
    bus.rd_end = 1;
    step(1);
    bus.rd_end = 0;
  endtask

  task automatic test_no_preempt();
    bus.wr_req = 1;
    step(1);
    bus.wr_req = 0;
    bus.ar_req = 1;
    bus.ar_end = 1; bus.rd_end = 1;
    step(1);
    bus.ar_end = 0; bus.rd_end = 0;
    step(2);
    checks++;
    if ({bus.ar_en, bus.wr_en, bus.rd_en} !== 3'b010) begin
      errors++;
      $display("FAIL no_preempt_hold got=%b exp=010", {bus.ar_en, bus.wr_en, bus.rd_en});
    end
    bus.wr_end = 1;
    step(1);
    bus.wr_end = 0;
    checks++;
    if ({bus.ar_en, bus.wr_en, bus.rd_en, bus.sdram_cmd} !== {3'b000, NOP}) begin
      errors++;
      $display("FAIL no_preempt_gap got=%b exp=0000111", {bus.ar_en, bus.wr_en, bus.rd_en, bus.sdram_cmd});
    end
    step(1);
    checks++;
    if ({bus.ar_en, bus.wr_en, bus.rd_en} !== 3'b100) begin
      errors++;
      $display("FAIL no_preempt_ar_after got=%b exp=100", {bus.ar_en, bus.wr_en, bus.rd_en});
    end
    bus.ar_req = 0;
    bus.ar_end = 1;
    step(1);
    bus.ar_end = 0;
  endtask

  task automatic test_dq();
    bus.wr_req = 1;
    step(1);
    bus.wr_req = 0;
    bus.wr_dq_en = 1; bus.wr_dq_data = 16'hA5C3;
    #1;
    checks++;
    if ({bus.sdram_dq_oe, bus.sdram_dq_out} !== {1'b1, 16'hA5C3}) begin
      errors++;
      $display("FAIL dq_write got=%h exp=%h", {bus.sdram_dq_oe, bus.sdram_dq_out}, {1'b1, 16'hA5C3});
    end
    bus.wr_dq_en = 0;
    #1;
    checks++;
    if ({bus.sdram_dq_oe, bus.sdram_dq_out} !== 17'h0) begin
      errors++;
      $display("FAIL dq_write_off got=%h exp=0", {bus.sdram_dq_oe, bus.sdram_dq_out});
    end
    bus.wr_end = 1; bus.rd_req = 1;
    step(1);
    bus.wr_end = 0;
    step(1);
    bus.rd_req = 0;
    bus.wr_dq_en = 1;
    #1;
    checks++;
    if ({bus.rd_en, bus.sdram_dq_oe, bus.sdram_dq_out} !== {1'b1, 17'h0}) begin
      errors++;
      $display("FAIL dq_read_off got=%h exp=%h", {bus.rd_en, bus.sdram_dq_oe, bus.sdram_dq_out}, {1'b1, 17'h0});
    end
    bus.wr_dq_en = 0;
  endtask

  task automatic test_reset_mid_read();
    bus.init_end = 0;
    arbit_rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.rd_en, bus.sdram_dq_oe, bus.sdram_cmd} !== {2'b00, 4'b0010}) begin
      errors++;
      $display("FAIL rst_mid_read got=%b exp=000010", {bus.rd_en, bus.sdram_dq_oe, bus.sdram_cmd});
    end
    @(negedge arbit_clk);
    arbit_rst_n = 1'b1;
    step(2);
    checks++;
    if ({bus.rd_en, bus.sdram_cmd, bus.sdram_addr} !== {1'b0, 4'b0010, 13'h0123}) begin
      errors++;
      $display("FAIL rst_passthru got=%h exp=%h", {bus.rd_en, bus.sdram_cmd, bus.sdram_addr},
               {1'b0, 4'b0010, 13'h0123});
    end
    bus.init_end = 1;
    step(1);
    checks++;
    if (bus.sdram_cmd !== NOP) begin
      errors++;
      $display("FAIL rst_reinit got=%b exp=%b", bus.sdram_cmd, NOP);
    end
  endtask

  task automatic test_random();
    logic [3:0]        e_cmd;
    logic [1:0]        e_bank;
    logic [ADDR_W-1:0] e_addr;
    logic [2:0]        e_gnt;
    logic [DQ_W:0]     e_dq;
    clear_inputs();
    apply_reset();
    model_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      bus.init_end   = (cyc < 6) ? 1'b0 : ($urandom_range(0, 7) != 0);
      bus.init_cmd   = 4'($urandom);   bus.init_bank = 2'($urandom); bus.init_addr = 13'($urandom);
      bus.ar_req     = ($urandom_range(0, 5) == 0);
      bus.wr_req     = ($urandom_range(0, 2) == 0);
      bus.rd_req     = ($urandom_range(0, 1) == 0);
      bus.ar_end     = ($urandom_range(0, 3) == 0);
      bus.wr_end     = ($urandom_range(0, 3) == 0);
      bus.rd_end     = ($urandom_range(0, 3) == 0);
      bus.ar_cmd     = 4'($urandom);   bus.ar_bank = 2'($urandom);   bus.ar_addr = 13'($urandom);
      bus.wr_cmd     = 4'($urandom);   bus.wr_bank = 2'($urandom);   bus.wr_addr = 13'($urandom);
      bus.rd_cmd     = 4'($urandom);   bus.rd_bank = 2'($urandom);   bus.rd_addr = 13'($urandom);
      bus.wr_dq_en   = 1'($urandom);
      bus.wr_dq_data = 16'($urandom);
      @(negedge arbit_clk);
      e_gnt = {m_owner == 0, m_owner == 1, m_owner == 2};
      if (!m_init) begin
        e_cmd = bus.init_cmd; e_bank = bus.init_bank; e_addr = bus.init_addr;
      end else if (m_owner == 0) begin
        e_cmd = bus.ar_cmd; e_bank = bus.ar_bank; e_addr = bus.ar_addr;
      end else if (m_owner == 1) begin
        e_cmd = bus.wr_cmd; e_bank = bus.wr_bank; e_addr = bus.wr_addr;
      end else if (m_owner == 2) begin
        e_cmd = bus.rd_cmd; e_bank = bus.rd_bank; e_addr = bus.rd_addr;
      end else begin
        e_cmd = NOP; e_bank = '0; e_addr = '0;
      end
      e_dq = (m_owner == 1 && bus.wr_dq_en) ? {1'b1, bus.wr_dq_data} : '0;
      checks++;
      if ({bus.ar_en, bus.wr_en, bus.rd_en, bus.sdram_cke} !== {e_gnt, 1'b1}) begin
        errors++;
        $display("FAIL rnd_grants cyc=%0d got=%b exp=%b", cyc,
                 {bus.ar_en, bus.wr_en, bus.rd_en, bus.sdram_cke}, {e_gnt, 1'b1});
      end
      checks++;
      if ({bus.sdram_cmd, bus.sdram_bank, bus.sdram_addr} !== {e_cmd, e_bank, e_addr}) begin
        errors++;
        $display("FAIL rnd_bus cyc=%0d got=%h exp=%h", cyc,
                 {bus.sdram_cmd, bus.sdram_bank, bus.sdram_addr}, {e_cmd, e_bank, e_addr});
      end
      checks++;
      if ({bus.sdram_dq_oe, bus.sdram_dq_out} !== e_dq) begin
        errors++;
        $display("FAIL rnd_dq cyc=%0d got=%h exp=%h", cyc, {bus.sdram_dq_oe, bus.sdram_dq_out}, e_dq);
      end
      @(posedge arbit_clk);
      model_edge();
      #1;
    end
  endtask

  initial begin
    arbit_rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_init_end();
    test_priority();
    test_no_preempt();
    test_dq();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
